led7_scan_ctrl: RTL

- Upstream feeder for the per-digit 7-segment decoder: time-multiplexes an N-digit hex/BCD value onto one shared decoder (BCD + enable) and drives active-low digit-select lines.
- Double-buffered load path so a new value only takes effect at a frame boundary, with no tearing.
- Per-slot blanking dead time suppresses ghosting between digits.

---
 rtl/led7_scan_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/led7_scan_ctrl.sv
// Time-multiplexed N-digit scan controller feeding one shared 7-segment decoder.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module led7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic [3:0]              BCD,
  output logic                    enable,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [2:0]              digit_idx,
  output logic                    frame_done
);

  logic [DIV_WIDTH-1:0]    div_cnt;
  logic [2:0]              idx;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [4*NUM_DIGITS-1:0] active_value;
  logic [NUM_DIGITS-1:0]   shadow_mask;
  logic [NUM_DIGITS-1:0]   active_mask;
  logic                    pending;

  logic                    slot_end;
  logic                    frame_end;
  logic                    blank;
  logic [3:0]              cur_nib;
  logic                    cur_en;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic [NUM_DIGITS-1:0]   lz_ok;

  assign slot_end  = (div_cnt == DIV_WIDTH'(DIV_MAX));
  assign frame_end = slot_end && (idx == 3'(NUM_DIGITS - 1));
  assign blank     = (div_cnt < DIV_WIDTH'(BLANK_CYCLES));

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; a digit is allowed once any nibble at or above it is nonzero.
  logic seen;
  always_comb begin
    seen  = 1'b0;
    lz_ok = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      seen = seen | (active_value[4*(NUM_DIGITS-1-j) +: 4] != 4'd0);
      lz_ok[NUM_DIGITS-1-j] = seen || (j == NUM_DIGITS - 1);
    end
  end
`else
  assign lz_ok = '1;
`endif

  always_comb begin
    cur_nib = '0;
    cur_en  = 1'b0;
    sel_n   = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == 3'(k)) begin
        cur_nib  = active_value[4*k +: 4];
        cur_en   = active_mask[k] & lz_ok[k];
        sel_n[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      idx          <= '0;
      shadow_value <= '0;
      active_value <= '0;
      shadow_mask  <= '0;
      active_mask  <= '0;
      pending      <= 1'b0;
      BCD          <= '0;
      enable       <= 1'b0;
      digit_sel    <= '1;
      digit_idx    <= '0;
      frame_done   <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + DIV_WIDTH'(1);
      if (slot_end)
        idx <= (idx == 3'(NUM_DIGITS - 1)) ? '0 : idx + 3'd1;

      // Swap reads the pre-edge shadow; a coincident load refills it and keeps pending set.
      if (frame_end && pending) begin
        active_value <= shadow_value;
        active_mask  <= shadow_mask;
      end
      if (load) begin
        shadow_value <= value;
        shadow_mask  <= digit_mask;
        pending      <= 1'b1;
      end else if (frame_end) begin
        pending      <= 1'b0;
      end

      BCD        <= cur_nib;
      enable     <= !blank && cur_en;
      digit_sel  <= blank ? '1 : sel_n;
      digit_idx  <= idx;
      frame_done <= frame_end;
    end
  end

endmodule
